// File: rtl/ca_ctrl_pkg.sv
// Shared types and defaults for the CA seed loader.
package ca_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_DONE
    } ca_ld_state_t;

    localparam int CA_N_CELLS = 5;
    localparam int CA_DIV     = 20000;

endpackage

// File: rtl/ca_bit_timer.sv
// Divider that paces one seed bit per DIV clk cycles and produces the
// load-clock square wave. Held at count 0 (phase high) while disabled.
module ca_bit_timer #(
    parameter int DIV = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic phase,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2);

    logic [CNT_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_phase;

    // Next divider count: wrap at DIV-1, clear whenever disabled.
    always_comb begin
        w_cnt_next = '0;
        if (en && (r_div_cnt != LAST)) begin
            w_cnt_next = r_div_cnt + CNT_W'(1);
        end
    end

    // Phase is registered from the next count so it always equals (div_cnt < DIV/2).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_phase   <= 1'b1;
        end else begin
            r_div_cnt <= w_cnt_next;
            r_phase   <= (w_cnt_next < HALF);
        end
    end

    assign phase    = r_phase;
    assign bit_tick = en && (r_div_cnt == LAST);

endmodule

// File: rtl/ca_seed_loader.sv
// Load/run controller for the Red_CA network: shifts the seed out MSB first
// under a divided load clock, lets the array settle, runs it for run_len
// cycles and captures Salida. All outputs come straight from flops.
module ca_seed_loader
    import ca_ctrl_pkg::*;
#(
    parameter int N_CELLS = CA_N_CELLS,
    parameter int DIV     = CA_DIV,
    parameter int RUN_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_CELLS-1:0] seed,
    input  logic [RUN_W-1:0]   run_len,
    input  logic [N_CELLS-1:0] ca_salida,
    output logic               ca_init,
    output logic               ca_carga,
    output logic               ca_clk_carga,
    output logic               ca_reset,
    output logic               ca_sync,
    output logic               busy,
    output logic               done,
    output logic [N_CELLS-1:0] snapshot
);

    localparam int IDX_W = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(N_CELLS - 1);

    ca_ld_state_t       r_state;
    ca_ld_state_t       w_state_next;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [IDX_W-1:0]   w_bit_idx_next;
    logic [RUN_W-1:0]   r_run_cnt;
    logic [RUN_W-1:0]   w_run_cnt_next;
    logic [N_CELLS-1:0] r_shift;
    logic [N_CELLS-1:0] w_shift_next;
    logic               w_timer_en;
    logic               w_bit_tick;
    logic               w_phase;

    logic               r_ca_init;
    logic               r_ca_carga;
    logic               r_ca_reset;
    logic               r_ca_sync;
    logic               r_busy;
    logic               r_done;
    logic [N_CELLS-1:0] r_snapshot;

    // The divider only runs while the load clock is being generated.
    assign w_timer_en = (r_state == ST_LOAD) || (r_state == ST_SETTLE);

    ca_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (w_timer_en),
        .phase    (w_phase),
        .bit_tick (w_bit_tick)
    );

    // Next-state logic; run_len is held as a down counter so the maximum never wraps.
    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        w_run_cnt_next = r_run_cnt;
        w_shift_next   = r_shift;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next   = ST_LOAD;
                    w_bit_idx_next = '0;
                    w_run_cnt_next = run_len;
                    w_shift_next   = seed;
                end
            end
            ST_LOAD: begin
                if (w_bit_tick) begin
                    w_shift_next   = r_shift << 1;
                    w_bit_idx_next = r_bit_idx + IDX_W'(1);
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_next = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (w_bit_tick) begin
                    w_state_next = (r_run_cnt == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_run_cnt_next = r_run_cnt - RUN_W'(1);
                if (r_run_cnt == RUN_W'(1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bit_idx  <= '0;
            r_run_cnt  <= '0;
            r_ca_init  <= 1'b0;
            r_ca_carga <= 1'b0;
            r_ca_reset <= 1'b1;
            r_ca_sync  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_snapshot <= '0;
        end else begin
            r_state    <= w_state_next;
            r_bit_idx  <= w_bit_idx_next;
            r_run_cnt  <= w_run_cnt_next;
            r_ca_init  <= (w_state_next == ST_LOAD) && w_shift_next[N_CELLS-1];
            r_ca_carga <= (w_state_next == ST_LOAD);
            r_ca_reset <= !((w_state_next == ST_RUN) || (w_state_next == ST_DONE));
            r_ca_sync  <= (w_state_next == ST_RUN);
            r_busy     <= (w_state_next != ST_IDLE);
            r_done     <= (w_state_next == ST_DONE);
            if (w_state_next == ST_DONE) begin
                r_snapshot <= ca_salida;
            end
        end
    end

    // Seed shift register carries data only and needs no reset.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_next;
    end

    assign ca_init      = r_ca_init;
    assign ca_carga     = r_ca_carga;
    assign ca_clk_carga = w_phase;
    assign ca_reset     = r_ca_reset;
    assign ca_sync      = r_ca_sync;
    assign busy         = r_busy;
    assign done         = r_done;
    assign snapshot     = r_snapshot;

endmodule

// File: doc/ca_seed_loader.md
# ca_seed_loader

Single-clock controller that drives the load/run side of the `Red_CA` cellular-automaton network. It serializes a parallel seed word onto the network's `init` line with `carga` asserted, generating `clk_carga` as a divided square wave. It then releases the network reset, runs it with `sync` for a programmed number of cycles, and captures the resulting `Salida` word. It replaces the hand-written load sequence in benches and is the hardware front end that feeds and reads the CA array.

## Interface
Parameters:
- `N_CELLS`, 5: number of CA cells; width of the seed and snapshot.
- `DIV`, 20000: `clk` cycles per `clk_carga` period, which is one seed bit. Must be even and ≥ 2.
- `RUN_W`, 16: width of `run_len`.

Ports:
- `clk`  in  1: the only clock.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request a load+run; sampled only in IDLE.
- `seed`  in  N_CELLS: initial cell values; latched on accepted `start`.
- `run_len`  in  RUN_W: number of `clk` cycles with `ca_sync`=1; latched on accepted `start`.
- `ca_salida`  in  N_CELLS: `Salida` from the CA network.
- `ca_init`  out  1: serial seed bit to the network.
- `ca_carga`  out  1: load enable.
- `ca_clk_carga`  out  1: load clock.
- `ca_reset`  out  1: network reset.
- `ca_sync`  out  1: run enable.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the snapshot is valid.
- `snapshot`  out  N_CELLS: captured `ca_salida`.

## Operation
- States: IDLE → LOAD → SETTLE → RUN → DONE → IDLE.
- **IDLE**
  - `ca_reset`=1, `ca_carga`=0, `ca_sync`=0, `ca_init`=0, `ca_clk_carga`=1.
  - `start`=1 latches `seed` and `run_len`, clears the bit index and divider, and moves to LOAD.
- **LOAD**
  - Lasts N_CELLS·DIV cycles. `ca_carga`=1, `ca_reset`=1.
  - `ca_init` = `seed_q[N_CELLS-1-bit_idx]`, so bits go out MSB first.
  - The divider `div_cnt` counts 0..DIV-1. `ca_clk_carga` = (`div_cnt` < DIV/2).
  - `ca_init` changes only at `div_cnt`=0, which is the `ca_clk_carga` rising edge. It is stable through the falling edge, where the network samples it.
  - `bit_idx` increments at `div_cnt`=DIV-1. After bit N_CELLS-1 the state moves to SETTLE.
- **SETTLE**
  - Lasts DIV cycles. `ca_carga`=0, `ca_reset`=1, `ca_init`=0.
  - `ca_clk_carga` keeps toggling with the same pattern.
- **RUN**
  - `ca_reset`=0, `ca_sync`=1 for exactly `run_len_q` cycles. `ca_clk_carga`=1.
  - If `run_len_q`=0, RUN is skipped: SETTLE goes directly to DONE.
- **DONE**
  - Lasts one cycle. `ca_sync`=0, `ca_reset`=0.
  - `snapshot` <= `ca_salida`; `done`=1. Next state is IDLE, where `ca_reset` returns to 1.
- `snapshot` holds its value until the next DONE.
- Changes to `seed`/`run_len` after acceptance have no effect.
- `start` outside IDLE, including during DONE, is ignored. It is not queued.
- `reset`=1 in any state forces IDLE and all outputs to their reset values on the next edge. An aborted load is not resumed.

## Timing
- Reset values:
  - `ca_reset`=1, `ca_clk_carga`=1.
  - `ca_init`, `ca_carga`, `ca_sync`, `busy`, `done` = 0.
  - `snapshot`=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Cycle landmarks, with `start` sampled at edge t:
  - LOAD occupies cycles t+1 … t+N_CELLS·DIV.
  - SETTLE occupies the next DIV cycles.
  - RUN occupies the next `run_len` cycles.
  - DONE occurs at t + (N_CELLS+1)·DIV + `run_len` + 1.
- `busy` rises at t+1 and falls at the edge leaving DONE.
- `run_len` at its maximum (2^RUN_W − 1) must complete without counter wrap.

## Structure
- Package `ca_ctrl_pkg` holds:
  - the state enum `ca_ld_state_t` (IDLE, LOAD, SETTLE, RUN, DONE);
  - the default constants `CA_N_CELLS`=5 and `CA_DIV`=20000.
- Sub-module `ca_bit_timer`:
  - parameter DIV;
  - inputs `clk`, `reset`, `en`;
  - outputs `phase` (drives `ca_clk_carga`) and `bit_tick` (asserted at `div_cnt`=DIV-1);
  - cleared whenever `en`=0.
- The FSM, bit index, run counter and snapshot register live in `ca_seed_loader`.

## Test plan
All scenarios use DIV=4 and N_CELLS=5.
1. **Reset:** assert `reset` 3 cycles, then release → outputs exactly at reset values; `busy`=0. `start` held with `reset`=1 → no state change.
2. **Seed load:** `start`, `seed`=5'b01010, `run_len`=3 →
   - `ca_init` = 0,1,0,1,0, each held 4 cycles;
   - `ca_carga`=1 for 20 cycles;
   - `ca_clk_carga` = 1,1,0,0 repeated 6 times through LOAD and SETTLE;
   - `ca_sync`=1 at t+25…t+27;
   - `done` at t+28; `snapshot` = the stubbed `ca_salida` 5'b10011 at that cycle.
3. **Zero run:** `run_len`=0 → `ca_sync` never 1; `done` at t+25.
4. **Ignored starts:** pulse `start` during LOAD and again during DONE with a different seed → no restart; the output sequence is unchanged; `busy` low for at least one cycle before the next accepted `start`.
5. **Reset mid-load:** assert `reset` at cycle t+7 → next cycle is IDLE with reset values. A new `start` replays the full 20-cycle load from bit 4.
6. **Latched inputs:** change `seed` and `run_len` every cycle after acceptance → serialized bits and run length match the values latched at `start`.
